execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute (E) stage of the 8-bit pipelined CPU. Sits between decode and the memory-access stage.
- Consumes decoded operands, computes the ALU result, maintains condition codes and resolves conditional jumps.
- Produces the registered E-stage bundle the memory stage latches: insCode_e, aluE_e, valC_e, dst_e, jmpFlag_e, increPC_e, writeReg_e, writeAluMem_e.
- Multiply is a multicycle shift-add operation that stalls decode.

Parameters:
- DATA_W, 8, datapath and address width.
- MUL_STEPS, DATA_W, shift-add iterations per multiply.

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- valid_d  input  1  decode presents a real instruction.
- insCode_d  input  4  opcode.
- fun_d  input  4  ALU function / jump condition.
- valA_d  input  DATA_W  operand A (register rA).
- valB_d  input  DATA_W  operand B (register rB).
- valC_d  input  DATA_W  immediate / memory address / jump target.
- dst_d  input  4  destination register index.
- increPC_d  input  DATA_W  fall-through PC.
- writeReg_d  input  1  instruction writes the register file.
- flush  input  1  squash the instruction entering E; driven when a taken jump reaches memory.
- stall_e  output  1  decode must hold its outputs; high while a multiply is iterating.
- halt_e  output  1  sticky; set once HALT executes.
- insCode_e, aluE_e, valC_e, dst_e, jmpFlag_e, increPC_e, writeReg_e, writeAluMem_e  output  4/DATA_W/DATA_W/4/1/DATA_W/1/1  registered E bundle.
- cc_e  output  4  {ZF,SF,OF,CF} condition codes.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All bundle outputs become 0; insCode_e=0 means NOP/bubble.
  - cc_e=4'b1000; stall_e=0; halt_e=0; FSM goes to IDLE.
  - Reset overrides everything, including a multiply in progress.
- Bubble definition: insCode_e=0, writeReg_e=0, jmpFlag_e=0, writeAluMem_e=0, other fields 0.
- A bubble is issued whenever any of these hold: valid_d=0, flush=1, halt_e=1, or the FSM is in MUL and not finishing.
- A squashed instruction never changes cc_e or halt_e.
- Latency: 1 edge, from inputs sampled to bundle registered.
- Opcodes:
  - 0000 NOP: bubble.
  - 0001 IRMOV: aluE=valC, writeAluMem=1.
  - 0010 RMMOV: aluE=valA (store data), writeReg forced 0.
  - 0011 MRMOV: aluE=valC, writeAluMem=0 (memory supplies the data).
  - 0100 OP: ALU on valA (op) valB, writeAluMem=1, cc updated.
  - 0101 JXX: see jump rules below.
  - 0110 HALT: sets halt_e, issues a bubble.
  - Others: bubble.
- OP functions:
  - 0 add, 1 sub (A-B), 2 and, 3 xor, 4 or, 5 shl by 1, 6 shr by 1 (logical), 7 mul (multicycle).
  - Results are truncated to DATA_W bits.
- Condition codes:
  - ZF = result==0; SF = result[MSB].
  - OF = signed overflow for add/sub, else 0.
  - CF = carry out for add, borrow for sub, bit shifted out for shl/shr, high product byte nonzero for mul, else 0.
  - cc is written at the same edge as the result, so the next instruction sees the new flags with no forwarding.
- JXX:
  - Conditions by fun: 0 always, 1 le (ZF|(SF^OF)), 2 lt (SF^OF), 3 eq (ZF), 4 ne, 5 ge, 6 gt; others are never taken.
  - Taken: jmpFlag_e=1, increPC_e=valC. Not taken: jmpFlag_e=0, increPC_e=increPC_d.
  - writeReg_e=0 in both cases.
- Every non-jump instruction passes increPC_e = increPC_d.
- Multiply FSM (states IDLE, MUL):
  - IDLE to MUL: on the edge that captures a valid, unflushed OP with fun=7. That edge latches the multiplicand, multiplier, dst and increPC, clears the accumulator and count, and issues a bubble.
  - stall_e = (state==MUL), combinational from state.
  - In MUL, each edge performs one shift-add step and inputs are ignored.
  - On the MUL_STEPS-th step the FSM returns to IDLE and registers the result bundle plus cc at that same edge. The result therefore appears MUL_STEPS edges after capture, with stall_e high for exactly MUL_STEPS cycles.
  - flush in MUL: abort to IDLE, issue a bubble, leave cc unchanged.
- halt_e blocks all later instructions until reset. A HALT that arrives while flush=1 is ignored.

Decomposition:
- Shared package cpu_defs holds: opcode constants (OP_NOP..OP_HALT), ALU function codes, jump condition codes, CC bit indices, DATA_W.
- Sub-module alu_comb: purely combinational; takes fun, A and B; returns result and the four flags (fun 0-6).
- The multiply FSM and the jump evaluation stay in execute_stage.

Test Plan:
- Reset, then IRMOV valC=0x12 dst=1 -> next edge: insCode_e=1, aluE_e=0x12, dst_e=1, writeReg_e=1, writeAluMem_e=1, cc_e=4'b1000.
- OP add 0x7F+0x01 -> aluE_e=0x80, cc_e={Z0,S1,O1,C0}. Then OP sub 0x05-0x05 -> aluE_e=0x00, ZF=1, CF=0.
- OP sub 0x03-0x05, then JXX lt valC=0x80 increPC_d=0x0B -> jmpFlag_e=1, increPC_e=0x80. Same sequence with JXX gt -> jmpFlag_e=0, increPC_e=0x0B.
- OP mul 0x13*0x11 -> stall_e high 8 cycles, bubbles meanwhile, then aluE_e=0x43, CF=1 (product 0x143).
- Multiply with flush asserted on cycle 3 -> stall_e drops the next cycle, bubble issued, cc_e unchanged.
- HALT followed by IRMOV -> halt_e=1, both issue bubbles. rst_n=0 mid-multiply -> next edge: stall_e=0, all outputs at reset values.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared CPU definitions: opcodes, ALU function codes, jump conditions,
// condition-code bit positions and the jump-condition evaluator.
package cpu_defs;

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_IRMOV = 4'd1;
  localparam logic [3:0] OP_RMMOV = 4'd2;
  localparam logic [3:0] OP_MRMOV = 4'd3;
  localparam logic [3:0] OP_OP    = 4'd4;
  localparam logic [3:0] OP_JXX   = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd6;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_XOR = 4'd3;
  localparam logic [3:0] FN_OR  = 4'd4;
  localparam logic [3:0] FN_SHL = 4'd5;
  localparam logic [3:0] FN_SHR = 4'd6;
  localparam logic [3:0] FN_MUL = 4'd7;

  localparam logic [3:0] JC_ALWAYS = 4'd0;
  localparam logic [3:0] JC_LE     = 4'd1;
  localparam logic [3:0] JC_LT     = 4'd2;
  localparam logic [3:0] JC_EQ     = 4'd3;
  localparam logic [3:0] JC_NE     = 4'd4;
  localparam logic [3:0] JC_GE     = 4'd5;
  localparam logic [3:0] JC_GT     = 4'd6;

  localparam int CC_ZF = 3;
  localparam int CC_SF = 2;
  localparam int CC_OF = 1;
  localparam int CC_CF = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_t;

  function automatic logic jump_taken(input logic [3:0] cond, input logic zf,
                                      input logic sf, input logic of);
    logic taken;
    case (cond)
      JC_ALWAYS: taken = 1'b1;
      JC_LE:     taken = zf | (sf ^ of);
      JC_LT:     taken = sf ^ of;
      JC_EQ:     taken = zf;
      JC_NE:     taken = ~zf;
      JC_GE:     taken = ~(sf ^ of);
      JC_GT:     taken = ~zf & ~(sf ^ of);
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute handshake plus the registered E-stage bundle.
interface execute_stage_if #(parameter int DATA_W = 8);

  logic              valid_d;
  logic [3:0]        insCode_d;
  logic [3:0]        fun_d;
  logic [DATA_W-1:0] valA_d;
  logic [DATA_W-1:0] valB_d;
  logic [DATA_W-1:0] valC_d;
  logic [3:0]        dst_d;
  logic [DATA_W-1:0] increPC_d;
  logic              writeReg_d;
  logic              flush;

  logic              stall_e;
  logic              halt_e;
  logic [3:0]        insCode_e;
  logic [DATA_W-1:0] aluE_e;
  logic [DATA_W-1:0] valC_e;
  logic [3:0]        dst_e;
  logic              jmpFlag_e;
  logic [DATA_W-1:0] increPC_e;
  logic              writeReg_e;
  logic              writeAluMem_e;
  logic [3:0]        cc_e;

  modport master (
    output valid_d, insCode_d, fun_d, valA_d, valB_d, valC_d, dst_d,
           increPC_d, writeReg_d, flush,
    input  stall_e, halt_e, insCode_e, aluE_e, valC_e, dst_e, jmpFlag_e,
           increPC_e, writeReg_e, writeAluMem_e, cc_e
  );

  modport slave (
    input  valid_d, insCode_d, fun_d, valA_d, valB_d, valC_d, dst_d,
           increPC_d, writeReg_d, flush,
    output stall_e, halt_e, insCode_e, aluE_e, valC_e, dst_e, jmpFlag_e,
           increPC_e, writeReg_e, writeAluMem_e, cc_e
  );

endinterface

// File: rtl/execute_stage_alu.sv
// Single-cycle ALU for functions 0-6; flags returned as {ZF,SF,OF,CF}.
module alu_comb #(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        fun,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);
  import cpu_defs::*;

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   wide_s;
  logic [DATA_W-1:0] res_s;
  logic              of_s;
  logic              cf_s;

  // Result, overflow and carry/borrow/shifted-out bit per function
  always_comb begin
    wide_s = '0;
    res_s  = '0;
    of_s   = 1'b0;
    cf_s   = 1'b0;
    case (fun)
      FN_ADD: begin
        wide_s = {1'b0, a} + {1'b0, b};
        res_s  = wide_s[DATA_W-1:0];
        cf_s   = wide_s[DATA_W];
        of_s   = (a[MSB] == b[MSB]) && (res_s[MSB] != a[MSB]);
      end
      FN_SUB: begin
        wide_s = {1'b0, a} - {1'b0, b};
        res_s  = wide_s[DATA_W-1:0];
        cf_s   = wide_s[DATA_W];
        of_s   = (a[MSB] != b[MSB]) && (res_s[MSB] != a[MSB]);
      end
      FN_AND: res_s = a & b;
      FN_XOR: res_s = a ^ b;
      FN_OR:  res_s = a | b;
      FN_SHL: begin
        res_s = {a[DATA_W-2:0], 1'b0};
        cf_s  = a[MSB];
      end
      FN_SHR: begin
        res_s = {1'b0, a[DATA_W-1:1]};
        cf_s  = a[0];
      end
      default: res_s = '0;
    endcase
  end

  assign result = res_s;
  assign flags  = {(res_s == '0), res_s[MSB], of_s, cf_s};

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU ops, condition codes, jump resolution and a
// shift-add multiply that stalls decode while it iterates.
module execute_stage #(
  parameter int DATA_W    = cpu_defs::DATA_W,
  parameter int MUL_STEPS = DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  execute_stage_if.slave bus
);
  import cpu_defs::*;

  localparam int CNT_W  = $clog2(MUL_STEPS + 1);
  localparam int PROD_W = 2 * DATA_W;

  ex_state_t state_r, state_s;
  logic [CNT_W-1:0]  count_r, count_s;
  logic [PROD_W-1:0] mcand_r, mcand_s;
  logic [PROD_W-1:0] acc_r, acc_s, step_acc_s;
  logic [DATA_W-1:0] mplier_r, mplier_s;
  logic [3:0]        mdst_r, mdst_s;
  logic [DATA_W-1:0] mpc_r, mpc_s;
  logic              mwr_r, mwr_s;

  logic [3:0]        ins_r, ins_s;
  logic [DATA_W-1:0] alu_r, alu_s;
  logic [DATA_W-1:0] valc_r, valc_s;
  logic [3:0]        dst_r, dst_s;
  logic              jmp_r, jmp_s;
  logic [DATA_W-1:0] pc_r, pc_s;
  logic              wreg_r, wreg_s;
  logic              wam_r, wam_s;
  logic [3:0]        cc_r, cc_s;
  logic              halt_r, halt_s;

  logic [DATA_W-1:0] alu_res_s;
  logic [3:0]        alu_cc_s;

  alu_comb #(.DATA_W(DATA_W)) u_alu (
    .fun    (bus.fun_d),
    .a      (bus.valA_d),
    .b      (bus.valB_d),
    .result (alu_res_s),
    .flags  (alu_cc_s)
  );

  assign step_acc_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  // Next-state, multiply datapath and next E bundle; defaults form a bubble
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    mcand_s  = mcand_r;
    acc_s    = acc_r;
    mplier_s = mplier_r;
    mdst_s   = mdst_r;
    mpc_s    = mpc_r;
    mwr_s    = mwr_r;
    ins_s    = OP_NOP;
    alu_s    = '0;
    valc_s   = '0;
    dst_s    = 4'd0;
    jmp_s    = 1'b0;
    pc_s     = '0;
    wreg_s   = 1'b0;
    wam_s    = 1'b0;
    cc_s     = cc_r;
    halt_s   = halt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.valid_d && !bus.flush && !halt_r) begin
          case (bus.insCode_d)
            OP_IRMOV: begin
              ins_s  = OP_IRMOV;
              alu_s  = bus.valC_d;
              valc_s = bus.valC_d;
              dst_s  = bus.dst_d;
              pc_s   = bus.increPC_d;
              wreg_s = bus.writeReg_d;
              wam_s  = 1'b1;
            end
            OP_RMMOV: begin
              ins_s  = OP_RMMOV;
              alu_s  = bus.valA_d;
              valc_s = bus.valC_d;
              dst_s  = bus.dst_d;
              pc_s   = bus.increPC_d;
            end
            OP_MRMOV: begin
              ins_s  = OP_MRMOV;
              alu_s  = bus.valC_d;
              valc_s = bus.valC_d;
              dst_s  = bus.dst_d;
              pc_s   = bus.increPC_d;
              wreg_s = bus.writeReg_d;
            end
            OP_OP: begin
              if (bus.fun_d == FN_MUL) begin
                state_s  = ST_MUL;
                count_s  = '0;
                acc_s    = '0;
                mcand_s  = {{DATA_W{1'b0}}, bus.valA_d};
                mplier_s = bus.valB_d;
                mdst_s   = bus.dst_d;
                mpc_s    = bus.increPC_d;
                mwr_s    = bus.writeReg_d;
              end else begin
                ins_s  = OP_OP;
                alu_s  = alu_res_s;
                valc_s = bus.valC_d;
                dst_s  = bus.dst_d;
                pc_s   = bus.increPC_d;
                wreg_s = bus.writeReg_d;
                wam_s  = 1'b1;
                cc_s   = alu_cc_s;
              end
            end
            OP_JXX: begin
              ins_s  = OP_JXX;
              valc_s = bus.valC_d;
              dst_s  = bus.dst_d;
              jmp_s  = jump_taken(bus.fun_d, cc_r[CC_ZF], cc_r[CC_SF], cc_r[CC_OF]);
              pc_s   = jmp_s ? bus.valC_d : bus.increPC_d;
            end
            OP_HALT: halt_s = 1'b1;
            default: ins_s = OP_NOP;
          endcase
        end else begin
          ins_s = OP_NOP;
        end
      end
      ST_MUL: begin
        if (bus.flush) begin
          state_s = ST_IDLE;
        end else begin
          acc_s    = step_acc_s;
          mcand_s  = {mcand_r[PROD_W-2:0], 1'b0};
          mplier_s = {1'b0, mplier_r[DATA_W-1:1]};
          count_s  = count_r + CNT_W'(1);
          // Last step: the product is complete in step_acc_s this cycle
          if (count_r == CNT_W'(MUL_STEPS - 1)) begin
            state_s = ST_IDLE;
            ins_s   = OP_OP;
            alu_s   = step_acc_s[DATA_W-1:0];
            dst_s   = mdst_r;
            pc_s    = mpc_r;
            wreg_s  = mwr_r;
            wam_s   = 1'b1;
            cc_s    = {(step_acc_s[DATA_W-1:0] == '0), step_acc_s[DATA_W-1], 1'b0,
                       (step_acc_s[PROD_W-1:DATA_W] != '0)};
          end else begin
            state_s = ST_MUL;
          end
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, multiply registers and registered E bundle with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      count_r  <= '0;
      mcand_r  <= '0;
      acc_r    <= '0;
      mplier_r <= '0;
      mdst_r   <= 4'd0;
      mpc_r    <= '0;
      mwr_r    <= 1'b0;
      ins_r    <= OP_NOP;
      alu_r    <= '0;
      valc_r   <= '0;
      dst_r    <= 4'd0;
      jmp_r    <= 1'b0;
      pc_r     <= '0;
      wreg_r   <= 1'b0;
      wam_r    <= 1'b0;
      cc_r     <= 4'b1000;
      halt_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      mcand_r  <= mcand_s;
      acc_r    <= acc_s;
      mplier_r <= mplier_s;
      mdst_r   <= mdst_s;
      mpc_r    <= mpc_s;
      mwr_r    <= mwr_s;
      ins_r    <= ins_s;
      alu_r    <= alu_s;
      valc_r   <= valc_s;
      dst_r    <= dst_s;
      jmp_r    <= jmp_s;
      pc_r     <= pc_s;
      wreg_r   <= wreg_s;
      wam_r    <= wam_s;
      cc_r     <= cc_s;
      halt_r   <= halt_s;
    end
  end

  assign bus.stall_e       = (state_r == ST_MUL);
  assign bus.halt_e        = halt_r;
  assign bus.insCode_e     = ins_r;
  assign bus.aluE_e        = alu_r;
  assign bus.valC_e        = valc_r;
  assign bus.dst_e         = dst_r;
  assign bus.jmpFlag_e     = jmp_r;
  assign bus.increPC_e     = pc_r;
  assign bus.writeReg_e    = wreg_r;
  assign bus.writeAluMem_e = wam_r;
  assign bus.cc_e          = cc_r;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  execute_stage_if #(.DATA_W(8)) bus ();

  execute_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] ins, input logic [3:0] fn,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [3:0] d, input logic [7:0] pc, input logic wr,
                       input logic fl);
    bus.valid_d    = v;
    bus.insCode_d  = ins;
    bus.fun_d      = fn;
    bus.valA_d     = a;
    bus.valB_d     = b;
    bus.valC_d     = c;
    bus.dst_d      = d;
    bus.increPC_d  = pc;
    bus.writeReg_d = wr;
    bus.flush      = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 4'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'd1, 4'd0, 8'hAA, 8'hBB, 8'hCC, 4'd5, 8'h33, 1'b1, 1'b0);
    step();
    step();
    checks++;
    if ({bus.insCode_e, bus.aluE_e, bus.valC_e, bus.dst_e, bus.jmpFlag_e, bus.increPC_e,
         bus.writeReg_e, bus.writeAluMem_e} !== 36'h0) begin
      failures++;
      $display("FAIL reset_bundle: got ins=%h alu=%h pc=%h wr=%b expected all zero",
               bus.insCode_e, bus.aluE_e, bus.increPC_e, bus.writeReg_e);
    end
    checks++;
    if ({bus.cc_e, bus.stall_e, bus.halt_e} !== 6'b1000_0_0) begin
      failures++;
      $display("FAIL reset_status: got cc=%b stall=%b halt=%b expected cc=1000 stall=0 halt=0",
               bus.cc_e, bus.stall_e, bus.halt_e);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_irmov_rmmov();
    drive(1'b1, 4'd1, 4'd0, 8'h00, 8'h00, 8'h12, 4'd1, 8'h02, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.insCode_e, bus.aluE_e, bus.dst_e, bus.writeReg_e, bus.writeAluMem_e,
         bus.increPC_e, bus.cc_e} !== {4'd1, 8'h12, 4'd1, 1'b1, 1'b1, 8'h02, 4'b1000}) begin
      failures++;
      $display("FAIL irmov: got ins=%h alu=%h dst=%h wr=%b wam=%b pc=%h cc=%b expected 1 12 1 1 1 02 1000",
               bus.insCode_e, bus.aluE_e, bus.dst_e, bus.writeReg_e, bus.writeAluMem_e,
               bus.increPC_e, bus.cc_e);
    end
    drive(1'b1, 4'd2, 4'd0, 8'h5A, 8'h00, 8'h40, 4'd2, 8'h04, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.insCode_e, bus.aluE_e, bus.valC_e, bus.writeReg_e, bus.increPC_e} !==
        {4'd2, 8'h5A, 8'h40, 1'b0, 8'h04}) begin
      failures++;
      $display("FAIL rmmov: got ins=%h alu=%h valC=%h wr=%b pc=%h expected 2 5a 40 0 04",
               bus.insCode_e, bus.aluE_e, bus.valC_e, bus.writeReg_e, bus.increPC_e);
    end
  endtask

  task automatic test_op();
    drive(1'b1, 4'd4, 4'd0, 8'h7F, 8'h01, 8'h00, 4'd3, 8'h06, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.aluE_e, bus.cc_e, bus.writeAluMem_e} !== {8'h80, 4'b0110, 1'b1}) begin
      failures++;
      $display("FAIL op_add: got alu=%h cc=%b wam=%b expected 80 0110 1",
               bus.aluE_e, bus.cc_e, bus.writeAluMem_e);
    end
    drive(1'b1, 4'd4, 4'd1, 8'h05, 8'h05, 8'h00, 4'd3, 8'h08, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.aluE_e, bus.cc_e} !== {8'h00, 4'b1000}) begin
      failures++;
      $display("FAIL op_sub_zero: got alu=%h cc=%b expected 00 1000", bus.aluE_e, bus.cc_e);
    end
    drive(1'b1, 4'd4, 4'd5, 8'h81, 8'h00, 8'h00, 4'd3, 8'h09, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.aluE_e, bus.cc_e} !== {8'h02, 4'b0001}) begin
      failures++;
      $display("FAIL op_shl: got alu=%h cc=%b expected 02 0001", bus.aluE_e, bus.cc_e);
    end
  endtask

  task automatic test_jump();
    drive(1'b1, 4'd4, 4'd1, 8'h03, 8'h05, 8'h00, 4'd3, 8'h0A, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.aluE_e, bus.cc_e} !== {8'hFE, 4'b0101}) begin
      failures++;
      $display("FAIL sub_neg: got alu=%h cc=%b expected fe 0101", bus.aluE_e, bus.cc_e);
    end
    drive(1'b1, 4'd5, 4'd2, 8'h00, 8'h00, 8'h80, 4'd0, 8'h0B, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.insCode_e, bus.jmpFlag_e, bus.increPC_e, bus.writeReg_e} !==
        {4'd5, 1'b1, 8'h80, 1'b0}) begin
      failures++;
      $display("FAIL jxx_lt: got ins=%h jmp=%b pc=%h wr=%b expected 5 1 80 0",
               bus.insCode_e, bus.jmpFlag_e, bus.increPC_e, bus.writeReg_e);
    end
    drive(1'b1, 4'd4, 4'd1, 8'h03, 8'h05, 8'h00, 4'd3, 8'h0A, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd5, 4'd6, 8'h00, 8'h00, 8'h80, 4'd0, 8'h0B, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.jmpFlag_e, bus.increPC_e, bus.writeReg_e} !== {1'b0, 8'h0B, 1'b0}) begin
      failures++;
      $display("FAIL jxx_gt: got jmp=%b pc=%h wr=%b expected 0 0b 0",
               bus.jmpFlag_e, bus.increPC_e, bus.writeReg_e);
    end
  endtask

  task automatic test_mul();
    drive(1'b1, 4'd4, 4'd7, 8'h13, 8'h11, 8'h00, 4'd3, 8'h20, 1'b1, 1'b0);
    step();
    // Decode keeps presenting something else; it must be ignored while iterating
    drive(1'b1, 4'd1, 4'd0, 8'h00, 8'h00, 8'hEE, 4'd7, 8'h21, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus.stall_e, bus.insCode_e, bus.cc_e} !== {1'b1, 4'd0, 4'b0101}) begin
        failures++;
        $display("FAIL mul_busy[%0d]: got stall=%b ins=%h cc=%b expected 1 0 0101",
                 i, bus.stall_e, bus.insCode_e, bus.cc_e);
      end
      step();
    end
    checks++;
    if ({bus.stall_e, bus.insCode_e, bus.aluE_e, bus.dst_e, bus.increPC_e, bus.cc_e} !==
        {1'b0, 4'd4, 8'h43, 4'd3, 8'h20, 4'b0001}) begin
      failures++;
      $display("FAIL mul_result: got stall=%b ins=%h alu=%h dst=%h pc=%h cc=%b expected 0 4 43 3 20 0001",
               bus.stall_e, bus.insCode_e, bus.aluE_e, bus.dst_e, bus.increPC_e, bus.cc_e);
    end
    idle();
    step();
  endtask

  task automatic test_mul_flush();
    drive(1'b1, 4'd4, 4'd7, 8'h13, 8'h11, 8'h00, 4'd3, 8'h30, 1'b1, 1'b0);
    step();
    idle();
    step();
    step();
    checks++;
    if (bus.stall_e !== 1'b1) begin
      failures++;
      $display("FAIL mul_flush_pre: got stall=%b expected 1", bus.stall_e);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if ({bus.stall_e, bus.insCode_e, bus.writeReg_e, bus.cc_e} !== {1'b0, 4'd0, 1'b0, 4'b0001}) begin
      failures++;
      $display("FAIL mul_flush: got stall=%b ins=%h wr=%b cc=%b expected 0 0 0 0001",
               bus.stall_e, bus.insCode_e, bus.writeReg_e, bus.cc_e);
    end
  endtask

  task automatic test_halt();
    drive(1'b1, 4'd6, 4'd0, 8'h00, 8'h00, 8'h00, 4'd0, 8'h40, 1'b0, 1'b1);
    step();
    checks++;
    if ({bus.halt_e, bus.insCode_e} !== {1'b0, 4'd0}) begin
      failures++;
      $display("FAIL halt_flushed: got halt=%b ins=%h expected 0 0", bus.halt_e, bus.insCode_e);
    end
    drive(1'b1, 4'd6, 4'd0, 8'h00, 8'h00, 8'h00, 4'd0, 8'h41, 1'b0, 1'b0);
    step();
    checks++;
    if ({bus.halt_e, bus.insCode_e, bus.increPC_e} !== {1'b1, 4'd0, 8'h00}) begin
      failures++;
      $display("FAIL halt: got halt=%b ins=%h pc=%h expected 1 0 00",
               bus.halt_e, bus.insCode_e, bus.increPC_e);
    end
    drive(1'b1, 4'd1, 4'd0, 8'h00, 8'h00, 8'h55, 4'd2, 8'h42, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.halt_e, bus.insCode_e, bus.aluE_e, bus.writeReg_e} !== {1'b1, 4'd0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL after_halt: got halt=%b ins=%h alu=%h wr=%b expected 1 0 00 0",
               bus.halt_e, bus.insCode_e, bus.aluE_e, bus.writeReg_e);
    end
  endtask

  task automatic test_reset_mid_mul();
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    drive(1'b1, 4'd4, 4'd7, 8'hFF, 8'hFF, 8'h00, 4'd3, 8'h50, 1'b1, 1'b0);
    step();
    idle();
    step();
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({bus.stall_e, bus.halt_e, bus.insCode_e, bus.aluE_e, bus.increPC_e, bus.cc_e} !==
        {1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'b1000}) begin
      failures++;
      $display("FAIL reset_mid_mul: got stall=%b halt=%b ins=%h alu=%h pc=%h cc=%b expected 0 0 0 00 00 1000",
               bus.stall_e, bus.halt_e, bus.insCode_e, bus.aluE_e, bus.increPC_e, bus.cc_e);
    end
    rst_n = 1'b1;
    // Pipeline must resume normally once reset is released
    drive(1'b1, 4'd1, 4'd0, 8'h00, 8'h00, 8'h9C, 4'd4, 8'h60, 1'b1, 1'b0);
    step();
    checks++;
    if ({bus.insCode_e, bus.aluE_e, bus.stall_e} !== {4'd1, 8'h9C, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_irmov: got ins=%h alu=%h stall=%b expected 1 9c 0",
               bus.insCode_e, bus.aluE_e, bus.stall_e);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    test_reset();
    test_irmov_rmmov();
    test_op();
    test_jump();
    test_mul();
    test_mul_flush();
    test_halt();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
